// File: rtl/micro_state_sequencer_pkg.sv
// Shared state and opcode constants for the multi-cycle RV32I micro-state sequencer.
// Perf counters are enabled by defining STATE_PERF_CNT_EN.
package micro_state_sequencer_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OPC_W   = 7;
  localparam int unsigned CNT_W   = 32;

  typedef enum logic [STATE_W-1:0] {
    S_IF_1  = 4'd0,
    S_IF_2  = 4'd1,
    S_IF_3  = 4'd2,
    S_IF_4  = 4'd3,
    S_ID    = 4'd4,
    S_EX_1  = 4'd5,
    S_EX_2  = 4'd6,
    S_MEM_1 = 4'd7,
    S_MEM_2 = 4'd8,
    S_MEM_3 = 4'd9,
    S_MEM_4 = 4'd10,
    S_WB    = 4'd11,
    S_HALT  = 4'd12
  } state_e;

  localparam logic [OPC_W-1:0] OP_ARITH     = 7'b0110011;
  localparam logic [OPC_W-1:0] OP_ARITH_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OP_LOAD      = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_STORE     = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_BRANCH    = 7'b1100011;
  localparam logic [OPC_W-1:0] OP_JAL       = 7'b1101111;
  localparam logic [OPC_W-1:0] OP_JALR      = 7'b1100111;
  localparam logic [OPC_W-1:0] OP_ECALL     = 7'b1110011;

  // Opcodes that proceed from ID into the execute phase.
  function automatic logic op_executes(input logic [OPC_W-1:0] op);
    case (op)
      OP_ARITH, OP_ARITH_IMM, OP_LOAD, OP_STORE,
      OP_BRANCH, OP_JAL, OP_JALR: op_executes = 1'b1;
      default:                    op_executes = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/micro_state_sequencer_if.sv
// Sequencer <-> control/datapath bundle. Counter signals exist only with STATE_PERF_CNT_EN.
interface micro_state_sequencer_if;
  import micro_state_sequencer_pkg::*;

  logic [OPC_W-1:0]   opcode;
  logic               halt_req;
  logic [STATE_W-1:0] current_state;
  logic               is_halted;
  logic               instr_done;
  logic               illegal_instr;
`ifdef STATE_PERF_CNT_EN
  logic [CNT_W-1:0]   cycle_count;
  logic [CNT_W-1:0]   instret_count;

  modport master (output opcode, halt_req,
                  input  current_state, is_halted, instr_done, illegal_instr,
                         cycle_count, instret_count);
  modport slave  (input  opcode, halt_req,
                  output current_state, is_halted, instr_done, illegal_instr,
                         cycle_count, instret_count);
`else
  modport master (output opcode, halt_req,
                  input  current_state, is_halted, instr_done, illegal_instr);
  modport slave  (input  opcode, halt_req,
                  output current_state, is_halted, instr_done, illegal_instr);
`endif

endinterface

// File: rtl/micro_state_sequencer_next.sv
// Combinational next-state, retire and illegal-opcode decode for the micro-state sequencer.
module micro_state_sequencer_next
  import micro_state_sequencer_pkg::*;
(
  input  state_e           state_i,
  input  logic [OPC_W-1:0] op_q_i,
  input  logic [OPC_W-1:0] opcode_i,
  input  logic             halt_req_i,
  output state_e           next_o,
  output logic             retire_o,
  output logic             illegal_o
);

  always_comb begin
    next_o    = S_IF_1;
    retire_o  = 1'b0;
    illegal_o = 1'b0;
    case (state_i)
      S_IF_1:  next_o = S_IF_2;
      S_IF_2:  next_o = S_IF_3;
      S_IF_3:  next_o = S_IF_4;
      S_IF_4:  next_o = S_ID;
      // Live opcode is only consulted here; later phases use the latched copy.
      S_ID: begin
        if (opcode_i == OP_ECALL) begin
          if (halt_req_i) next_o   = S_HALT;
          else            retire_o = 1'b1;
        end else if (op_executes(opcode_i)) begin
          next_o = S_EX_1;
        end else begin
          retire_o  = 1'b1;
          illegal_o = 1'b1;
        end
      end
      S_EX_1:  next_o = S_EX_2;
      S_EX_2: begin
        case (op_q_i)
          OP_LOAD, OP_STORE:                      next_o   = S_MEM_1;
          OP_ARITH, OP_ARITH_IMM, OP_JAL, OP_JALR: next_o   = S_WB;
          default:                                retire_o = 1'b1;
        endcase
      end
      S_MEM_1: next_o = S_MEM_2;
      S_MEM_2: next_o = S_MEM_3;
      S_MEM_3: next_o = S_MEM_4;
      S_MEM_4: begin
        if (op_q_i == OP_LOAD) next_o   = S_WB;
        else                   retire_o = 1'b1;
      end
      S_WB:    retire_o = 1'b1;
      S_HALT:  next_o   = S_HALT;
      default: next_o   = S_IF_1;
    endcase
  end

endmodule

// File: rtl/micro_state_sequencer.sv
// Micro-state sequencer top: state/op registers, registered pulses and, with
// STATE_PERF_CNT_EN defined, cycle and retired-instruction counters.
module micro_state_sequencer
  import micro_state_sequencer_pkg::*;
#(
  parameter int unsigned STATE_WIDTH = 4,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  micro_state_sequencer_if.slave  bus
);

  if (STATE_WIDTH != STATE_W || CNT_WIDTH != CNT_W) begin : g_width_chk
    $error("micro_state_sequencer: STATE_WIDTH/CNT_WIDTH must match package widths");
  end

  state_e           state_q, state_d;
  logic [OPC_W-1:0] op_q, op_d;
  logic             done_q, illegal_q, halted_q;
  logic             retire_c, illegal_c;

  micro_state_sequencer_next u_next (
    .state_i    (state_q),
    .op_q_i     (op_q),
    .opcode_i   (bus.opcode),
    .halt_req_i (bus.halt_req),
    .next_o     (state_d),
    .retire_o   (retire_c),
    .illegal_o  (illegal_c)
  );

  assign op_d = (state_q == S_ID) ? bus.opcode : op_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IF_1;
      op_q      <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      done_q    <= retire_c;
      illegal_q <= illegal_c;
      halted_q  <= (state_d == S_HALT);
    end
  end

  assign bus.current_state = STATE_W'(state_q);
  assign bus.instr_done    = done_q;
  assign bus.illegal_instr = illegal_q;
  assign bus.is_halted     = halted_q;

`ifdef STATE_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] cyc_q, cyc_d, ret_q, ret_d;

  // The halting ECALL counts as retired even though it raises no instr_done.
  assign cyc_d = (state_q == S_HALT) ? cyc_q : cyc_q + CNT_WIDTH'(1);
  assign ret_d = (retire_c || (state_d == S_HALT && state_q != S_HALT))
                 ? ret_q + CNT_WIDTH'(1) : ret_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      ret_q <= ret_d;
    end
  end

  assign bus.cycle_count   = CNT_W'(cyc_q);
  assign bus.instret_count = CNT_W'(ret_q);
`endif

endmodule

// File: tb/tb_micro_state_sequencer.sv
// Randomized self-checking bench for micro_state_sequencer; counter checks
// are active when STATE_PERF_CNT_EN is defined.
module tb_micro_state_sequencer;
  import micro_state_sequencer_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  micro_state_sequencer_if bus ();

  micro_state_sequencer #(.STATE_WIDTH(4), .CNT_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: pulses owed at the next IF_1 and counter expectations.
  logic        exp_done = 1'b0;
  logic        exp_ill  = 1'b0;
  logic [31:0] exp_cyc  = '0;
  logic [31:0] exp_ret  = '0;

  logic [6:0] ops [9] = '{OP_ARITH, OP_ARITH_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
                          OP_JAL, OP_JALR, OP_ECALL, OP_ECALL};

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic chk_cycle(input int st, input logic d, input logic il, input logic h);
    chk("current_state", 32'(bus.current_state), 32'(st));
    chk("instr_done",    32'(bus.instr_done),    32'(d));
    chk("illegal_instr", 32'(bus.illegal_instr), 32'(il));
    chk("is_halted",     32'(bus.is_halted),     32'(h));
`ifdef STATE_PERF_CNT_EN
    chk("cycle_count",   bus.cycle_count,   exp_cyc);
    chk("instret_count", bus.instret_count, exp_ret);
`endif
  endtask

  // Runs one instruction from an IF_1 cycle (positioned just after a falling edge).
  task automatic run_instr(input logic [6:0] op, input logic hr, input int cpi,
                           input logic fix, input logic [6:0] fix_op, input int abort_st);
    int   path[$];
    int   kind;
    logic ex, mem, wb;
    path = {0, 1, 2, 3, 4};
    kind = 0; ex = 1'b0; mem = 1'b0; wb = 1'b0;
    case (op)
      OP_ECALL:                                kind = hr ? 2 : 0;
      OP_BRANCH:                               ex = 1'b1;
      OP_ARITH, OP_ARITH_IMM, OP_JAL, OP_JALR: begin ex = 1'b1; wb = 1'b1; end
      OP_STORE:                                begin ex = 1'b1; mem = 1'b1; end
      OP_LOAD:                                 begin ex = 1'b1; mem = 1'b1; wb = 1'b1; end
      default:                                 kind = 1;
    endcase
    if (ex) begin path.push_back(5); path.push_back(6); end
    if (mem) for (int s = 7; s <= 10; s++) path.push_back(s);
    if (wb) path.push_back(11);
    if (cpi != 0) chk("cpi", 32'(path.size()), 32'(cpi));

    for (int i = 0; i < path.size(); i++) begin
      chk_cycle(path[i], (i == 0) ? exp_done : 1'b0, (i == 0) ? exp_ill : 1'b0, 1'b0);
      if (path[i] == abort_st) return;
      bus.opcode   = (path[i] == 4) ? op : (fix ? fix_op : 7'($urandom));
      bus.halt_req = (path[i] == 4) ? hr : 1'($urandom);
      @(posedge clk);
      exp_cyc++;
      if (i == path.size() - 1) exp_ret++;
      @(negedge clk); #1;
    end
    exp_done = (kind != 2);
    exp_ill  = (kind == 1);
    if (kind == 2) begin
      for (int k = 0; k < 21; k++) begin
        chk_cycle(12, 1'b0, 1'b0, 1'b1);
        bus.opcode   = 7'($urandom);
        bus.halt_req = 1'($urandom);
        @(posedge clk);
        @(negedge clk); #1;
      end
      exp_done = 1'b0;
    end
  endtask

  // Asynchronous reset asserted between edges; ends positioned at an IF_1 cycle.
  task automatic do_reset();
    #1 reset = 1'b0;
    #1;
    exp_cyc = '0; exp_ret = '0; exp_done = 1'b0; exp_ill = 1'b0;
    chk_cycle(0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); #1 reset = 1'b1;
  endtask

  initial begin
    logic [6:0] op;
    logic       hr;
    reset        = 1'b0;
    bus.opcode   = '0;
    bus.halt_req = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_cycle(0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;

    run_instr(OP_ARITH, 1'b0, 8, 1'b1, OP_ARITH, -1);
    chk("pin_alu_state", 32'(bus.current_state), 32'd0);
    chk("pin_alu_done",  32'(bus.instr_done),    32'd1);
`ifdef STATE_PERF_CNT_EN
    chk("pin_alu_cycles",  bus.cycle_count,   32'd8);
    chk("pin_alu_instret", bus.instret_count, 32'd1);
`endif
    run_instr(OP_LOAD,   1'b0, 12, 1'b0, '0, -1);
    run_instr(OP_STORE,  1'b0, 11, 1'b0, '0, -1);
    run_instr(OP_BRANCH, 1'b0, 7,  1'b0, '0, -1);
    run_instr(OP_BRANCH, 1'b0, 7,  1'b1, OP_LOAD, -1);
    run_instr(OP_ECALL,  1'b0, 5,  1'b0, '0, -1);
    run_instr(7'b0000000, 1'b1, 5, 1'b0, '0, -1);
    chk("pin_illegal_pulse", 32'(bus.illegal_instr), 32'd1);
    chk("pin_illegal_done",  32'(bus.instr_done),    32'd1);

    // Unused encoding 14 must fall back to IF_1 with no pulses.
    chk_cycle(0, exp_done, exp_ill, 1'b0);
    force dut.state_q = state_e'(4'd14);
    #1;
    release dut.state_q;
    chk("forced_state", 32'(bus.current_state), 32'd14);
    @(posedge clk);
    exp_cyc++;
    @(negedge clk); #1;
    exp_done = 1'b0; exp_ill = 1'b0;
    run_instr(OP_JAL, 1'b0, 8, 1'b0, '0, -1);

    run_instr(OP_LOAD, 1'b0, 12, 1'b0, '0, 8);
    do_reset();

    run_instr(OP_ECALL, 1'b1, 5, 1'b0, '0, -1);
    chk("pin_halt_flag", 32'(bus.is_halted), 32'd1);
`ifdef STATE_PERF_CNT_EN
    chk("pin_halt_cycles",  bus.cycle_count,   32'd5);
    chk("pin_halt_instret", bus.instret_count, 32'd1);
`endif
    do_reset();

    for (int n = 0; n < 80; n++) begin
      int r;
      r  = $urandom_range(0, 9);
      op = (r == 9) ? (7'($urandom) & 7'b1111100) : ops[r];
      hr = ($urandom_range(0, 3) == 0);
      run_instr(op, hr, 0, 1'b0, '0, -1);
      if (op == OP_ECALL && hr) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
